// File: rtl/memctrl_pkg.sv
// Shared types, width helpers and reset levels for the multi-bank SRAM controller.
package memctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } cmd_e;

    localparam logic CSB_RST_LVL = 1'b1;
    localparam logic WEB_RST_LVL = 1'b1;

    function automatic int bank_sel_w(input int nbank);
        return $clog2(nbank);
    endfunction

    function automatic int in_bank_w(input int aw, input int nbank);
        return aw - $clog2(nbank);
    endfunction

    // WEB=1 with OEB=1 is a no-op even when the chip is selected.
    function automatic cmd_e decode_cmd(input logic ce, input logic csb,
                                        input logic web, input logic oeb);
        if (!ce || csb) return NOP;
        if (!web)       return WRITE;
        if (!oeb)       return READ;
        return NOP;
    endfunction

endpackage

// File: rtl/memctrl_rd_pipe.sv
// Read-return pipeline: delays {valid, bank} by RD_LAT cycles, then registers BK_Q of that bank.
module memctrl_rd_pipe
    import memctrl_pkg::*;
#(
    parameter int DW     = 8,
    parameter int NBANK  = 4,
    parameter int RD_LAT = 1
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic                              vld_i,
    input  logic [bank_sel_w(NBANK)-1:0]      bank_i,
    input  logic [NBANK*DW-1:0]               bk_q_i,
    output logic [DW-1:0]                     odata_o,
    output logic                              rvalid_o
);
    localparam int BSW = bank_sel_w(NBANK);

    logic [RD_LAT-1:0] vld_q;
    logic [BSW-1:0]    bank_q [RD_LAT];
    logic [DW-1:0]     q_bank [NBANK];
    logic [DW-1:0]     odata_q;
    logic              rvalid_q;

    always_comb begin
        for (int b = 0; b < NBANK; b++) q_bank[b] = bk_q_i[b*DW +: DW];
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            vld_q    <= '0;
            rvalid_q <= 1'b0;
            odata_q  <= '0;
        end else begin
            vld_q[0] <= vld_i;
            for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
            rvalid_q <= vld_q[RD_LAT-1];
            if (vld_q[RD_LAT-1]) odata_q <= q_bank[bank_q[RD_LAT-1]];
        end
    end

    // Bank tags need no reset: they are only used when the matching valid bit is set.
    always_ff @(posedge clk_i) begin
        bank_q[0] <= bank_i;
        for (int i = 1; i < RD_LAT; i++) bank_q[i] <= bank_q[i-1];
    end

    assign odata_o  = odata_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: rtl/memctrl_mb.sv
// Multi-bank SRAM controller: burst FSM, beat counter and in-bank address incrementer.
module memctrl_mb
    import memctrl_pkg::*;
#(
    parameter int DW     = 8,
    parameter int AW     = 16,
    parameter int NBANK  = 4,
    parameter int BLW    = 4,
    parameter int RD_LAT = 1
) (
    input  logic                            CLK,
    input  logic                            RSTN,
    input  logic                            CE,
    input  logic                            CSB,
    input  logic                            WEB,
    input  logic                            OEB,
    input  logic [AW-1:0]                   ADDR,
    input  logic [BLW-1:0]                  BLEN,
    input  logic [DW-1:0]                   IDATA,
    output logic [DW-1:0]                   ODATA,
    output logic                            RVALID,
    output logic                            BUSY,
    output logic                            DROP,
    output logic [NBANK-1:0]                BK_CSB,
    output logic                            BK_WEB,
    output logic [in_bank_w(AW,NBANK)-1:0]  BK_A,
    output logic [DW-1:0]                   BK_D,
    input  logic [NBANK*DW-1:0]             BK_Q
);
    localparam int BSW = bank_sel_w(NBANK);
    localparam int BAW = in_bank_w(AW, NBANK);

    state_e           state_q, state_d;
    logic [BLW-1:0]   rem_q, rem_d;
    logic [BAW-1:0]   addr_q, addr_d;
    logic [BSW-1:0]   bank_q, bank_d;
    logic [NBANK-1:0] bk_csb_q, bk_csb_d;
    logic             bk_web_q, bk_web_d;
    logic [BAW-1:0]   bk_a_q, bk_a_d;
    logic [DW-1:0]    bk_d_q, bk_d_d;
    logic             drop_q, drop_d;
    cmd_e             cmd;
    logic             last_beat;
    logic             can_accept;
    logic             rd_beat;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        addr_d   = addr_q;
        bank_d   = bank_q;
        bk_csb_d = bk_csb_q;
        bk_web_d = bk_web_q;
        bk_a_d   = bk_a_q;
        bk_d_d   = bk_d_q;
        drop_d   = 1'b0;

        cmd        = decode_cmd(CE, CSB, WEB, OEB);
        last_beat  = (rem_q == '0);
        // The edge that ends a burst can already start the next one.
        can_accept = (state_q == IDLE) || last_beat;

        unique case (state_q)
            IDLE: ;
            WR, RD: begin
                if (last_beat) begin
                    state_d  = IDLE;
                    bk_csb_d = '1;
                    bk_web_d = 1'b1;
                end else begin
                    bk_a_d = addr_q;
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (state_q == WR) bk_d_d = IDATA;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cmd != NOP) begin
            if (can_accept) begin
                state_d  = (cmd == WRITE) ? WR : RD;
                bank_d   = ADDR[AW-1 -: BSW];
                bk_csb_d = ~({{(NBANK-1){1'b0}}, 1'b1} << bank_d);
                bk_a_d   = ADDR[BAW-1:0];
                addr_d   = ADDR[BAW-1:0] + 1'b1;
                rem_d    = BLEN;
                bk_web_d = (cmd != WRITE);
                if (cmd == WRITE) bk_d_d = IDATA;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            bk_csb_q <= {NBANK{CSB_RST_LVL}};
            bk_web_q <= WEB_RST_LVL;
            bk_a_q   <= '0;
            bk_d_q   <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            bk_csb_q <= bk_csb_d;
            bk_web_q <= bk_web_d;
            bk_a_q   <= bk_a_d;
            bk_d_q   <= bk_d_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge CLK) begin
        addr_q <= addr_d;
        bank_q <= bank_d;
    end

    assign rd_beat = bk_web_q & ~(&bk_csb_q);

    memctrl_rd_pipe #(
        .DW     (DW),
        .NBANK  (NBANK),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i    (CLK),
        .rstn_i   (RSTN),
        .vld_i    (rd_beat),
        .bank_i   (bank_q),
        .bk_q_i   (BK_Q),
        .odata_o  (ODATA),
        .rvalid_o (RVALID)
    );

    assign BUSY   = (state_q != IDLE);
    assign DROP   = drop_q;
    assign BK_CSB = bk_csb_q;
    assign BK_WEB = bk_web_q;
    assign BK_A   = bk_a_q;
    assign BK_D   = bk_d_q;

endmodule

// File: doc/memctrl_mb.md
Name: memctrl_mb

Overview:
Parametrised multi-bank SRAM controller. Successor to the fixed 4-bank, 8-bit, single-access MEMCTRL.
- Generalised in data width, address width and bank count.
- Adds auto-incrementing bursts with in-bank wrap, configurable macro read latency, and a read-valid, busy and drop handshake.
- Sits between the host-side CE/CSB/WEB/OEB bus and NBANK synchronous single-port SRAM macros.

Parameters:
DW, 8, data width in bits.
AW, 16, host address width.
NBANK, 4, bank count; power of 2, at least 2. Bank select is ADDR[AW-1 -: log2(NBANK)].
BLW, 4, burst-length field width; max burst is 2^BLW beats.
RD_LAT, 1, SRAM macro read latency in cycles (1..4).
Derived: BAW = AW - log2(NBANK), the in-bank address width.

Ports:
CLK  in  1  single clock; all logic on rising edge.
RSTN  in  1  reset, synchronous, active-low.
CE  in  1  command enable.
CSB  in  1  chip select, active-low.
WEB  in  1  write enable, active-low.
OEB  in  1  output enable, active-low.
ADDR  in  AW  burst start address.
BLEN  in  BLW  burst length minus 1.
IDATA  in  DW  write data.
ODATA  out  DW  read data, registered.
RVALID  out  1  ODATA holds a new beat this cycle.
BUSY  out  1  burst in progress; commands are not accepted.
DROP  out  1  one-cycle pulse: a command arrived while BUSY.
BK_CSB  out  NBANK  per-bank chip select, active-low.
BK_WEB  out  1  shared macro write enable, active-low.
BK_A  out  BAW  shared in-bank address.
BK_D  out  DW  shared macro write data.
BK_Q  in  NBANK*DW  macro read data; bank b occupies [b*DW +: DW].

Behaviour:
- Reset: synchronous, active-low; RSTN=0 sampled at an edge applies reset at that edge.
  - Reset values: BK_CSB all 1, BK_WEB=1, BK_A=0, BK_D=0, ODATA=0, RVALID=0, BUSY=0, DROP=0, state IDLE.
  - Mid-burst reset aborts the burst at that edge: no further bank access, read pipeline flushed, no RVALID after reset.
- Command valid: CE=1 and CSB=0.
  - Write: WEB=0; OEB is ignored.
  - Read: WEB=1 and OEB=0.
  - WEB=1 and OEB=1: no-op; no state change, no DROP.
- Accept: a valid command with BUSY=0 is captured at edge k. Captured fields: bank, in-bank address, N = BLEN+1, direction.
- States: IDLE, WR, RD. A write command goes IDLE->WR at edge k; a read goes IDLE->RD. Both return to IDLE after beat N-1 is issued.
- Beat i (0..N-1):
  - Outputs driven in the cycle after edge k+i: BK_CSB[bank]=0, BK_A = start + i mod 2^BAW. The address wraps within the bank; the bank never changes.
  - Macro samples the beat at edge k+i+1.
  - Write: IDATA is sampled at edge k+i, driven on BK_D, BK_WEB=0.
  - Read: BK_WEB=1. IDATA is ignored for reads.
- Read return: beat i is registered from BK_Q[bank] into ODATA at edge k+i+1+RD_LAT, with RVALID=1 for that cycle.
  - The bank-select/valid pipeline lives in memctrl_rd_pipe, depth RD_LAT.
  - ODATA holds its last value when RVALID=0.
- Busy window: BUSY=1 for cycles after edges k..k+N-1 and drops at edge k+N. All BK_CSB return to 1 at edge k+N.
- Back-to-back: the next command is accepted at edge k+N if presented then. The read pipeline may still be draining; RVALID order is preserved.
- DROP: a valid command sampled while BUSY=1 is discarded and DROP=1 for the following cycle. The current burst is unaffected.
- Host timing: all host inputs are sampled only at edges; no combinational path from input to output.

Decomposition:
- Package memctrl_pkg:
  - state enum {IDLE, WR, RD};
  - cmd enum {NOP, WRITE, READ};
  - function clog2-based BANK_SEL_W / BAW derivation;
  - reset-value constants.
- Sub-module memctrl_rd_pipe (RD_LAT-deep shift register of {valid, bank}) selects BK_Q and registers ODATA/RVALID.
- Top contains the FSM, beat counter and address incrementer.

Test Plan:
- Write burst: ADDR=0x4000, BLEN=3, IDATA 0xA0..0xA3 on consecutive edges -> BK_CSB=4'b1101 for 4 cycles, BK_A=0..3, BK_WEB=0. Read back with BLEN=3 -> RVALID 4 consecutive cycles, ODATA 0xA0,0xA1,0xA2,0xA3, first beat at accept+2 (RD_LAT=1).
- In-bank wrap: write/read ADDR=0x7FFE, BLEN=3 -> BK_A 0x3FFE, 0x3FFF, 0x0000, 0x0001, all on bank 1; readback data matches.
- Single-beat all banks: write 0x0000/0x4000/0x8000/0xC000 with 0x11/0x22/0x33/0x44, BLEN=0 -> each BK_CSB bit exercised once; reads return 0x11..0x44 in order.
- Collision: second command during 8-beat burst -> DROP=1 for one cycle; burst completes with 8 beats; BUSY falls at edge accept+8.
- Reset mid-read: RSTN=0 at beat 2 of 8-beat read -> next cycle BK_CSB all 1, BUSY=0, RVALID=0, ODATA=0, no further RVALID.
- RD_LAT=3 build, NBANK=8, DW=16: read BLEN=1 at 0xE000 -> bank 7 selected; RVALID at accept+4 and accept+5 with written data.
